// File: rtl/perf_mon_pkg.sv
// rtl/perf_mon_pkg.sv - shared mode/state types and reset defaults for perf_event_monitor
package perf_mon_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_LEVEL = 2'b01,
    MODE_EDGE  = 2'b10,
    MODE_CYCLE = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_HALTED = 2'b10
  } state_e;

  // Channel 0 tracks total run cycles out of reset; the rest count event levels.
  localparam mode_e MODE_RST_CH0   = MODE_CYCLE;
  localparam mode_e MODE_RST_OTHER = MODE_LEVEL;

endpackage

// File: rtl/perf_counter_ch.sv
// rtl/perf_counter_ch.sv - one event channel: mode, counter, edge detect, overflow, shadow (PERF_MON_THRESH_IRQ_EN adds threshold hit)
module perf_counter_ch
  import perf_mon_pkg::*;
#(
  parameter int         CNT_W    = 16,
  parameter int         SAT_MODE = 0,
  parameter logic [1:0] RST_MODE = MODE_LEVEL
) (
  input  logic             clk,
  input  logic             RST_N,
  input  logic             run,
  input  logic             clear,
  input  logic             event_in,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_mode,
  input  logic             snap,
`ifdef PERF_MON_THRESH_IRQ_EN
  input  logic [CNT_W-1:0] thresh,
  output logic             thresh_hit,
`endif
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] shadow,
  output logic             ovf
);

  mode_e            mode_q;
  logic             ev_prev_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] shadow_q;
  logic             ovf_q;
  logic             inc;
  logic             all_ones;

  // Mode decode: decide whether this cycle produces an increment (current mode applies).
  always_comb begin
    inc = 1'b0;
    case (mode_q)
      MODE_LEVEL: inc = event_in;
      MODE_EDGE:  inc = event_in && !ev_prev_q;
      MODE_CYCLE: inc = 1'b1;
      default:    inc = 1'b0;
    endcase
    inc      = inc && run;
    all_ones = &cnt_q;
  end

  // Counter, overflow, mode and shadow state; clear beats increment, snapshot sees pre-update value.
  always_ff @(posedge clk) begin
    if (!RST_N) begin
      mode_q    <= mode_e'(RST_MODE);
      ev_prev_q <= 1'b0;
      cnt_q     <= '0;
      shadow_q  <= '0;
      ovf_q     <= 1'b0;
    end else begin
      ev_prev_q <= event_in;
      if (cfg_we) mode_q <= mode_e'(cfg_mode);
      if (snap) shadow_q <= cnt_q;
      if (clear) begin
        cnt_q <= '0;
        ovf_q <= 1'b0;
      end else if (inc) begin
        if (all_ones) begin
          ovf_q <= 1'b1;
          cnt_q <= (SAT_MODE != 0) ? cnt_q : '0;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end
  end

`ifdef PERF_MON_THRESH_IRQ_EN
  logic upd_q;

  // Remember that the counter value actually changed, so a match means "just arrived at threshold".
  always_ff @(posedge clk) begin
    if (!RST_N) upd_q <= 1'b0;
    else        upd_q <= !clear && inc && !((SAT_MODE != 0) && all_ones);
  end

  assign thresh_hit = upd_q && (cnt_q == thresh);
`endif

  assign cnt    = cnt_q;
  assign shadow = shadow_q;
  assign ovf    = ovf_q;

endmodule

// File: rtl/perf_event_monitor.sv
// rtl/perf_event_monitor.sv - run/halt FSM, config decode and read mux over NUM_CH counters (optional PERF_MON_THRESH_IRQ_EN)
module perf_event_monitor
  import perf_mon_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int CNT_W    = 16,
  parameter int SAT_MODE = 0,
  parameter int SEL_W    = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              RST_N,
  input  logic              start_i,
  input  logic              halt_i,
  input  logic              clear_i,
  input  logic [NUM_CH-1:0] event_i,
  input  logic              cfg_we_i,
  input  logic [SEL_W-1:0]  cfg_ch_i,
  input  logic [1:0]        cfg_mode_i,
  input  logic              snap_req_i,
  output logic              snap_ack_o,
  input  logic [SEL_W-1:0]  rd_sel_i,
  input  logic              rd_shadow_i,
  output logic [CNT_W-1:0]  rd_data_o,
  output logic [NUM_CH-1:0] ovf_o,
`ifdef PERF_MON_THRESH_IRQ_EN
  input  logic              thresh_we_i,
  input  logic [CNT_W-1:0]  thresh_i,
  output logic              irq_o,
`endif
  output logic [1:0]        state_o
);

  state_e           state_q, state_d;
  logic             run;
  logic             snap_ack_q;
  logic [CNT_W-1:0] rd_data_q, rd_data_d;
  logic [CNT_W-1:0] cnt_w    [NUM_CH];
  logic [CNT_W-1:0] shadow_w [NUM_CH];

  // State register.
  always_ff @(posedge clk) begin
    if (!RST_N) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state: clear dominates; HALTED is left only by clear.
  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:   if (start_i) state_d = ST_RUN;
        ST_RUN:    if (halt_i)  state_d = ST_HALTED;
        ST_HALTED: state_d = ST_HALTED;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  assign run = (state_q == ST_RUN);

`ifdef PERF_MON_THRESH_IRQ_EN
  logic [NUM_CH-1:0] hit_w;
  logic [CNT_W-1:0]  thresh_q;
  logic              irq_q;
`endif

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    perf_counter_ch #(
      .CNT_W   (CNT_W),
      .SAT_MODE(SAT_MODE),
      .RST_MODE((g == 0) ? MODE_RST_CH0 : MODE_RST_OTHER)
    ) u_ch (
      .clk       (clk),
      .RST_N     (RST_N),
      .run       (run),
      .clear     (clear_i),
      .event_in  (event_i[g]),
      .cfg_we    (cfg_we_i && (cfg_ch_i == SEL_W'(g))),
      .cfg_mode  (cfg_mode_i),
      .snap      (snap_req_i),
`ifdef PERF_MON_THRESH_IRQ_EN
      .thresh    (thresh_q),
      .thresh_hit(hit_w[g]),
`endif
      .cnt       (cnt_w[g]),
      .shadow    (shadow_w[g]),
      .ovf       (ovf_o[g])
    );
  end

  // Read mux: unmatched selects (>= NUM_CH) fall through to zero.
  always_comb begin
    rd_data_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_sel_i == SEL_W'(i)) rd_data_d = rd_shadow_i ? shadow_w[i] : cnt_w[i];
    end
  end

  // Registered read data and snapshot acknowledge.
  always_ff @(posedge clk) begin
    if (!RST_N) begin
      rd_data_q  <= '0;
      snap_ack_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      snap_ack_q <= snap_req_i;
    end
  end

`ifdef PERF_MON_THRESH_IRQ_EN
  // Common threshold register and sticky interrupt level.
  always_ff @(posedge clk) begin
    if (!RST_N) begin
      thresh_q <= '1;
      irq_q    <= 1'b0;
    end else begin
      if (thresh_we_i) thresh_q <= thresh_i;
      if (clear_i)     irq_q <= 1'b0;
      else if (|hit_w) irq_q <= 1'b1;
    end
  end

  assign irq_o = irq_q;
`endif

  assign rd_data_o  = rd_data_q;
  assign snap_ack_o = snap_ack_q;
  assign state_o    = state_q;

endmodule

// File: doc/perf_event_monitor.md
Name: perf_event_monitor

Overview:
Parametrised pipeline performance-monitor unit that replaces the fixed cycle, jump, branch and load-use counters inside the CPU top.
- NUM_CH independent event counters, each CNT_W bits wide.
- Each channel has a configurable counting mode.
- Counting is gated by a run/halt state machine driven by the CPU halt signal.
- An atomic snapshot (shadow bank) lets the display/debug path read a consistent set of counts while live counting continues.

Parameters:
NUM_CH, 4, number of event channels (2..16)
CNT_W, 16, counter width in bits (8..32)
SAT_MODE, 0, 0 = counters wrap modulo 2^CNT_W; 1 = counters saturate at all-ones
SEL_W, $clog2(NUM_CH), derived width of channel-select fields

Ports:
clk  in  1  system clock; all state updates on posedge
RST_N  in  1  synchronous reset, active-low
start_i  in  1  one-cycle pulse: IDLE->RUN
halt_i  in  1  CPU halted level (WB halt); RUN->HALTED
clear_i  in  1  one-cycle pulse: zero all live counters and overflow flags; return to IDLE
event_i  in  NUM_CH  per-channel event strobes from the pipeline
cfg_we_i  in  1  mode-register write strobe
cfg_ch_i  in  SEL_W  channel addressed by the mode write
cfg_mode_i  in  2  mode value written
snap_req_i  in  1  one-cycle pulse: copy all live counters to the shadow bank
snap_ack_o  out  1  one-cycle pulse, one cycle after the accepted snap_req_i
rd_sel_i  in  SEL_W  channel to read
rd_shadow_i  in  1  1 = read the shadow bank, 0 = read the live counter
rd_data_o  out  CNT_W  registered read data
ovf_o  out  NUM_CH  sticky per-channel overflow flags
state_o  out  2  current FSM state (00 IDLE, 01 RUN, 10 HALTED)

Behaviour:
- Clock and reset are fixed: one clock, clk. Reset RST_N is synchronous and active-low.
- Reset (RST_N=0 at posedge):
  - All counters, shadow registers, ovf_o, rd_data_o and snap_ack_o go to 0.
  - state_o goes to IDLE.
  - Mode registers reset to: ch0 = CYCLE, all others = LEVEL.
  - A reset mid-run discards everything, including any snapshot in progress.
- FSM:
  - IDLE: nothing counts. start_i -> RUN.
  - RUN: counting enabled. halt_i=1 -> HALTED.
  - HALTED: counts frozen. Only clear_i or reset leaves this state. start_i is ignored.
  - clear_i from any state -> IDLE. clear_i has priority over start_i and halt_i in the same cycle.
- Modes (2 bits):
  - 00 OFF: never counts.
  - 01 LEVEL: +1 every RUN cycle in which event_i[ch]=1.
  - 10 EDGE: +1 on each 0->1 transition of event_i[ch]. The previous-value register updates in every state, so an edge that straddles IDLE->RUN counts only if the rising cycle occurs in RUN.
  - 11 CYCLE: +1 every RUN cycle; event_i[ch] is ignored.
- Halt timing:
  - In the cycle where halt_i first rises, the FSM is still in RUN and that cycle is counted.
  - Freeze takes effect the next cycle. A halted cycle-count therefore includes the halting cycle.
- Overflow:
  - Increment from all-ones sets ovf_o[ch]. The flag is sticky until clear_i or reset.
  - SAT_MODE=0: counter wraps to 0.
  - SAT_MODE=1: counter holds all-ones.
- Simultaneous events:
  - clear_i with an event: the counter becomes 0; clear wins.
  - cfg_we_i with an event on the same channel: the old mode applies this cycle, the new mode from the next cycle.
  - snap_req_i with an increment: the shadow captures the pre-increment value, i.e. the value registered at that posedge.
  - snap_req_i with clear_i: the snapshot captures pre-clear values and is acked.
- Snapshot:
  - Accepted in any state.
  - Shadow bank updated at the posedge sampling snap_req_i.
  - snap_ack_o pulses exactly one cycle later.
  - Back-to-back requests are each acked.
- Read path:
  - rd_data_o is registered with 1-cycle latency from rd_sel_i/rd_shadow_i.
  - rd_sel_i >= NUM_CH returns 0.
  - Reads never disturb counting.
- Out-of-range cfg_ch_i: the write is ignored.

Optional Feature:
Macro PERF_MON_THRESH_IRQ_EN.
- Defined:
  - Adds ports thresh_we_i (1), thresh_i (CNT_W), and irq_o (1).
  - thresh_we_i writes a common threshold.
  - irq_o is a level that sets when any channel in LEVEL, EDGE or CYCLE mode transitions to a value equal to the threshold. It stays set until clear_i or reset.
  - The threshold resets to all-ones.
- Not defined:
  - The ports and logic are absent.
  - All other behaviour is identical.

Decomposition:
- Package perf_mon_pkg holds:
  - the mode enum (MODE_OFF, MODE_LEVEL, MODE_EDGE, MODE_CYCLE);
  - the state enum (ST_IDLE, ST_RUN, ST_HALTED);
  - the reset-default mode constants.
- One sub-module, perf_counter_ch, is instantiated NUM_CH times. It contains:
  - the counter;
  - the edge register;
  - mode decode;
  - wrap/saturate logic;
  - the ovf flag;
  - the shadow register.
- The top level holds the FSM, the config decode, and the read mux.

Test Plan:
1. Basic counting (defaults):
   - Stimulus: reset, start, hold event_i[1]=1 for 10 cycles, then pulse halt_i.
   - Required: ch1 live = 10; ch0 = cycles from RUN entry through the halt cycle inclusive; state_o = 10.
   - Further stimulus: additional events and start_i.
   - Required: counts do not change.
2. EDGE mode:
   - Stimulus: set ch2 to EDGE; drive event_i[2] as 1,1,0,1,0,1,1.
   - Required: ch2 = 3.
   - Stimulus: in the same cycle as an event, write ch2 to OFF.
   - Required: that event is counted and later ones are not.
3. Overflow (CNT_W=8, ch1 LEVEL, 257 event cycles):
   - SAT_MODE=0: ch1 = 1, ovf_o[1] = 1.
   - SAT_MODE=1: ch1 = 255, ovf_o[1] = 1.
   - After clear_i: ch1 = 0, ovf_o = 0, state IDLE.
4. Snapshot consistency:
   - Stimulus: ch0 CYCLE in RUN; snap_req_i at live value 37.
   - Required: snap_ack_o on the next cycle; shadow read = 37 while live continues (e.g. 40 three cycles later); rd_data_o appears 1 cycle after rd_sel_i.
5. Reset and priority:
   - Stimulus: assert RST_N=0 mid-RUN.
   - Required: all outputs 0 at the next posedge.
   - Stimulus: clear_i and start_i in the same cycle.
   - Required: state IDLE.
   - Stimulus: rd_sel_i = NUM_CH.
   - Required: rd_data_o = 0.
6. Threshold IRQ (PERF_MON_THRESH_IRQ_EN defined):
   - Stimulus: threshold = 5, ch1 LEVEL.
   - Required: irq_o rises in the cycle after ch1 reaches 5; it stays high through later counts until clear_i.
